// File: rtl/count_sequencer.sv
// Run/stop/limit sequencer: counts 0..limit one-shot or continuously, with pause/resume.
// Optional TICK_DIV_EN macro enables a DIV-clock prescaler between count steps.
module count_sequencer #(
  parameter int WIDTH = 3,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  if (DIV < 1) begin : g_bad_div
    $error("count_sequencer: DIV must be at least 1");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             tick;

`ifdef TICK_DIV_EN
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;

  assign tick = (presc_q == PW'(DIV - 1));
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
`ifdef TICK_DIV_EN
    presc_d = presc_q;
`endif

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !stop) begin
          state_d = RUN;
          count_d = '0;
          limit_d = limit;
          mode_d  = mode;
          busy_d  = 1'b1;
`ifdef TICK_DIV_EN
          presc_d = '0;
`endif
        end
      end

      RUN: begin
        // Stop takes priority over any tick that lands in the same cycle.
        if (stop) begin
          state_d = HOLD;
        end else begin
`ifdef TICK_DIV_EN
          presc_d = tick ? '0 : presc_q + 1'b1;
`endif
          if (tick) begin
            if (count_q < limit_q) begin
              count_d = count_q + 1'b1;
            end else if (!mode_q) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              count_d = '0;
              wrap_d  = 1'b1;
            end
          end
        end
      end

      HOLD: begin
        if (start && !stop) begin
          state_d = RUN;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef TICK_DIV_EN
      presc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
`ifdef TICK_DIV_EN
      presc_q <= presc_d;
`endif
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer; tick period follows TICK_DIV_EN (DIV=4) or 1.
module tb_count_sequencer;

  localparam int WIDTH = 3;
  localparam int DIV   = 4;
`ifdef TICK_DIV_EN
  localparam int TP = DIV;
`else
  localparam int TP = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;

  int checks = 0;
  int errors = 0;

  count_sequencer #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .limit (limit),
    .count (count),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; limit = '0;
    step(); step();
    checks++;
    if ({count, busy, done, wrap} !== 6'b000_000) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b want %b (count,busy,done,wrap)", {count, busy, done, wrap}, 6'b000_000);
    end
    start = 1'b1; limit = 3'd5;
    step();
    checks++;
    if ({count, busy, done, wrap} !== 6'b000_000) begin
      errors++;
      $display("[TB] FAIL reset_overrides_start: got %b want %b", {count, busy, done, wrap}, 6'b000_000);
    end
    rst_n = 1'b1; start = 1'b0;
    step();
    checks++;
    if ({count, busy, done, wrap} !== 6'b000_000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %b want %b", {count, busy, done, wrap}, 6'b000_000);
    end
  endtask

  task automatic test_reset_mid_run();
    mode = 1'b0; limit = 3'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5 * TP) step();
    checks++;
    if ({count, busy, done, wrap} !== {3'd5, 3'b100}) begin
      errors++;
      $display("[TB] FAIL mid_run_count5: got %b want %b", {count, busy, done, wrap}, {3'd5, 3'b100});
    end
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({count, busy, done, wrap} !== 6'b000_000) begin
      errors++;
      $display("[TB] FAIL mid_run_reset: got %b want %b", {count, busy, done, wrap}, 6'b000_000);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({count, busy, done, wrap} !== 6'b000_000) begin
      errors++;
      $display("[TB] FAIL mid_run_reset_idle: got %b want %b", {count, busy, done, wrap}, 6'b000_000);
    end
  endtask

  task automatic test_one_shot();
    logic [WIDTH-1:0] e;
    mode = 1'b0; limit = 3'd3; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({count, busy, done, wrap} !== {3'd0, 3'b100}) begin
      errors++;
      $display("[TB] FAIL one_shot_start: got %b want %b", {count, busy, done, wrap}, {3'd0, 3'b100});
    end
    for (int k = 1; k <= 3; k++) begin
      e = WIDTH'(k);
      repeat (TP) step();
      checks++;
      if ({count, busy, done, wrap} !== {e, 3'b100}) begin
        errors++;
        $display("[TB] FAIL one_shot_count%0d: got %b want %b", k, {count, busy, done, wrap}, {e, 3'b100});
      end
    end
    start = 1'b1;
    repeat (TP) step();
    checks++;
    if ({count, busy, done, wrap} !== {3'd3, 3'b010}) begin
      errors++;
      $display("[TB] FAIL one_shot_done: got %b want %b", {count, busy, done, wrap}, {3'd3, 3'b010});
    end
    step();
    checks++;
    if ({count, busy, done, wrap} !== {3'd3, 3'b000}) begin
      errors++;
      $display("[TB] FAIL done_to_idle_ignores_start: got %b want %b", {count, busy, done, wrap}, {3'd3, 3'b000});
    end
    step();
    checks++;
    if ({count, busy, done, wrap} !== {3'd0, 3'b100}) begin
      errors++;
      $display("[TB] FAIL restart_from_idle: got %b want %b", {count, busy, done, wrap}, {3'd0, 3'b100});
    end
    go_idle();
  endtask

  task automatic test_continuous();
    logic [WIDTH-1:0] e;
    mode = 1'b1; limit = 3'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e = (i % 3 == 2) ? 3'd0 : WIDTH'(i % 3 + 1);
      repeat (TP) step();
      checks++;
      if ({count, busy, done, wrap} !== {e, 1'b1, 1'b0, (e == 3'd0)}) begin
        errors++;
        $display("[TB] FAIL continuous_step%0d: got %b want %b", i, {count, busy, done, wrap}, {e, 1'b1, 1'b0, (e == 3'd0)});
      end
    end
    e = (TP == 1) ? 3'd1 : 3'd0;
    step();
    checks++;
    if ({count, busy, done, wrap} !== {e, 3'b100}) begin
      errors++;
      $display("[TB] FAIL wrap_one_cycle: got %b want %b", {count, busy, done, wrap}, {e, 3'b100});
    end
    go_idle();
  endtask

  task automatic test_hold();
    mode = 1'b0; limit = 3'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4 * TP) step();
    checks++;
    if ({count, busy, done, wrap} !== {3'd4, 3'b100}) begin
      errors++;
      $display("[TB] FAIL hold_reach4: got %b want %b", {count, busy, done, wrap}, {3'd4, 3'b100});
    end
    stop = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({count, busy, done, wrap} !== {3'd4, 3'b100}) begin
        errors++;
        $display("[TB] FAIL hold_frozen%0d: got %b want %b", i, {count, busy, done, wrap}, {3'd4, 3'b100});
      end
    end
    stop = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if ({count, busy, done, wrap} !== {3'd4, 3'b100}) begin
      errors++;
      $display("[TB] FAIL resume_edge: got %b want %b", {count, busy, done, wrap}, {3'd4, 3'b100});
    end
    repeat (TP) step();
    checks++;
    if ({count, busy, done, wrap} !== {3'd5, 3'b100}) begin
      errors++;
      $display("[TB] FAIL resume_count5: got %b want %b", {count, busy, done, wrap}, {3'd5, 3'b100});
    end
    go_idle();
  endtask

  task automatic test_limit_zero();
    mode = 1'b0; limit = 3'd0; start = 1'b1;
    step();
    start = 1'b0; limit = 3'd5;
    repeat (TP) step();
    checks++;
    if ({count, busy, done, wrap} !== {3'd0, 3'b010}) begin
      errors++;
      $display("[TB] FAIL limit0_one_shot_done: got %b want %b", {count, busy, done, wrap}, {3'd0, 3'b010});
    end
    step();
    checks++;
    if ({count, busy, done, wrap} !== {3'd0, 3'b000}) begin
      errors++;
      $display("[TB] FAIL limit0_idle: got %b want %b", {count, busy, done, wrap}, {3'd0, 3'b000});
    end
    mode = 1'b1; limit = 3'd0; start = 1'b1;
    step();
    start = 1'b0; limit = 3'd3; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (TP) step();
      checks++;
      if ({count, busy, done, wrap} !== {3'd0, 3'b101}) begin
        errors++;
        $display("[TB] FAIL limit0_wrap%0d: got %b want %b", i, {count, busy, done, wrap}, {3'd0, 3'b101});
      end
    end
    go_idle();
  endtask

  task automatic test_full_range();
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] prev;
    mode = 1'b1; limit = 3'd7; start = 1'b1;
    step();
    start = 1'b0;
    prev = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      e = WIDTH'(i);
      for (int j = 0; j < TP - 1; j++) begin
        step();
        checks++;
        if ({count, busy, done, wrap} !== {prev, 3'b100}) begin
          errors++;
          $display("[TB] FAIL full_range_between%0d_%0d: got %b want %b", i, j, {count, busy, done, wrap}, {prev, 3'b100});
        end
      end
      step();
      checks++;
      if ({count, busy, done, wrap} !== {e, 1'b1, 1'b0, (e == 3'd0)}) begin
        errors++;
        $display("[TB] FAIL full_range_tick%0d: got %b want %b", i, {count, busy, done, wrap}, {e, 1'b1, 1'b0, (e == 3'd0)});
      end
      prev = e;
    end
    go_idle();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; limit = '0;
    test_reset();
    test_reset_mid_run();
    test_one_shot();
    test_continuous();
    test_hold();
    test_limit_zero();
    test_full_range();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
